// File: rtl/core_dbg_scanner.sv
// Sweeps the RV32 core debug port from address 0 to NUM_REGS-1 and streams
// each captured (address, data) pair to a downstream consumer over valid/ready.
module core_dbg_scanner #(
    parameter int NUM_REGS = 128,
    parameter int SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        debug_en_o,
    output logic        debug_step_o,
    output logic [6:0]  debug_addr_o,
    input  logic [31:0] debug_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [6:0]  out_addr_o,
    output logic [31:0] out_data_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT,
        S_DONE
    } state_e;

    localparam logic [6:0] LAST_ADDR   = 7'(NUM_REGS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [6:0]  oaddr_q, oaddr_d;
    logic [31:0] odata_q, odata_d;
    logic        en_q, en_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic settleDone;
    logic lastAddr;

    assign settleDone = (cnt_q == SETTLE_LAST);
    assign lastAddr   = (addr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Abort outranks a same-cycle handshake so a discarded entry is never counted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort_i)         state_d = S_IDLE;
                else if (settleDone) state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (abort_i)          state_d = S_IDLE;
                else if (out_ready_i) state_d = lastAddr ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values plus output flags decoded from the next state,
    // so every output leaves a flop.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = '0;
                    cnt_d  = '0;
                end
            end
            S_SETTLE: begin
                if (abort_i) begin
                    addr_d = '0;
                    cnt_d  = '0;
                end else if (settleDone) begin
                    odata_d = debug_data_i;
                    oaddr_d = addr_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PRESENT: begin
                if (abort_i) begin
                    addr_d = '0;
                    cnt_d  = '0;
                end else if (out_ready_i && !lastAddr) begin
                    addr_d = addr_q + 7'd1;
                    cnt_d  = '0;
                end
            end
            S_DONE: begin
                addr_d = '0;
                cnt_d  = '0;
            end
            default: begin
                addr_d = '0;
                cnt_d  = '0;
            end
        endcase

        en_d    = (state_d == S_SETTLE) || (state_d == S_PRESENT);
        valid_d = (state_d == S_PRESENT);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign debug_en_o   = en_q;
    assign debug_step_o = 1'b0;
    assign debug_addr_o = addr_q;
    assign out_valid_o  = valid_q;
    assign out_addr_o   = oaddr_q;
    assign out_data_o   = odata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_core_dbg_scanner.sv
// Randomized bench for core_dbg_scanner: a transaction-level model of the sweep
// predicts every output each cycle, plus directed backpressure/abort/reset cases.
module tb_core_dbg_scanner;

    localparam int NUM_REGS = 128;
    localparam int SETTLE   = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        outReady;
    logic        debugEn;
    logic        debugStep;
    logic [6:0]  debugAddr;
    logic [31:0] debugData;
    logic        outValid;
    logic [6:0]  outAddr;
    logic [31:0] outData;
    logic        busy;
    logic        done;
    logic [31:0] salt;

    // Reference model: where the sweep is, not how the FSM encodes it
    bit          mBusy, mEn, mValid, mDone, mAddrKnown;
    int          mAddr, mSettleLeft;
    logic [6:0]  mOutAddr;
    logic [31:0] mOutData;

    int nChecks, nPass, cyc;
    int hsCount, doneCount, nextHsAddr, bpCycles, lastDoneCyc;

    core_dbg_scanner #(.NUM_REGS(NUM_REGS), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start),
        .abort_i      (abort),
        .debug_en_o   (debugEn),
        .debug_step_o (debugStep),
        .debug_addr_o (debugAddr),
        .debug_data_i (debugData),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_addr_o   (outAddr),
        .out_data_o   (outData),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addrHash(input logic [6:0] a);
        return {25'd0, a} * 32'h1111_1111;
    endfunction

    assign debugData = addrHash(debugAddr) ^ salt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic modelReset();
        mBusy = 0; mEn = 0; mValid = 0; mDone = 0; mAddrKnown = 1;
        mAddr = 0; mSettleLeft = 0; mOutAddr = '0; mOutData = '0;
    endtask

    task automatic modelStep(input bit s, input bit a, input bit r);
        if (mDone) begin
            mDone = 0; mBusy = 0; mAddr = 0; mAddrKnown = 1;
        end else if (!mBusy) begin
            if (s) begin
                mBusy = 1; mEn = 1; mAddr = 0; mAddrKnown = 1; mSettleLeft = SETTLE;
            end
        end else if (a) begin
            mBusy = 0; mEn = 0; mValid = 0; mAddrKnown = 0;
        end else if (mValid) begin
            if (r) begin
                mValid = 0;
                if (mAddr == NUM_REGS - 1) begin
                    mDone = 1; mEn = 0;
                end else begin
                    mAddr++; mSettleLeft = SETTLE;
                end
            end
        end else begin
            mSettleLeft--;
            if (mSettleLeft == 0) begin
                mValid   = 1;
                mOutAddr = 7'(mAddr);
                mOutData = addrHash(7'(mAddr)) ^ salt;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("debug_en", 32'(debugEn), 32'(mEn));
        checkOutput("debug_step", 32'(debugStep), 32'd0);
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("out_valid", 32'(outValid), 32'(mValid));
        if (mAddrKnown) checkOutput("debug_addr", 32'(debugAddr), 32'(mAddr));
        if (mValid) begin
            checkOutput("out_addr", 32'(outAddr), 32'(mOutAddr));
            checkOutput("out_data", outData, mOutData);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".debug_en"}, 32'(debugEn), 32'd0);
        checkOutput({tag, ".debug_step"}, 32'(debugStep), 32'd0);
        checkOutput({tag, ".debug_addr"}, 32'(debugAddr), 32'd0);
        checkOutput({tag, ".out_valid"}, 32'(outValid), 32'd0);
        checkOutput({tag, ".out_addr"}, 32'(outAddr), 32'd0);
        checkOutput({tag, ".out_data"}, outData, 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge,
    // then check the DUT against it half a cycle later.
    task automatic applyStimulus(input bit s, input bit a, input bit r);
        if (mValid && $urandom_range(0, 2) == 0) salt = $urandom;
        if (outValid && r && !a) begin
            hsCount++;
            checkOutput("hs_order", 32'(outAddr), 32'(nextHsAddr));
            nextHsAddr++;
        end
        if (outValid && !r && !a) bpCycles++;
        start = s; abort = a; outReady = r;
        modelStep(s, a, r);
        @(negedge clk);
        cyc++;
        if (done) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
        compareAll();
    endtask

    task automatic clearCounters();
        hsCount = 0; doneCount = 0; nextHsAddr = 0; bpCycles = 0; lastDoneCyc = -1;
    endtask

    task automatic runSweep(input int readyPct, input int startPct, input int abortPct,
                            input bit bp5, input bit checkLen);
        int startCyc, guard, bpLeft;
        bit s, a, r;
        clearCounters();
        bpLeft   = bp5 ? 5 : 0;
        startCyc = cyc;
        applyStimulus(1, 0, 1);
        guard = 0;
        while (mBusy && guard < 5000) begin
            s = ($urandom_range(0, 99) < startPct) || mDone;
            a = ($urandom_range(0, 99) < abortPct);
            r = ($urandom_range(0, 99) < readyPct);
            if (bp5 && mValid && mAddr == 1 && bpLeft > 0) begin
                r = 0; a = 0; bpLeft--;
            end
            applyStimulus(s, a, r);
            guard++;
        end
        if (guard >= 5000) checkOutput("sweep_timeout", 32'd0, 32'd1);
        if (abortPct == 0) begin
            checkOutput("entries", 32'(hsCount), 32'(NUM_REGS));
            checkOutput("done_count", 32'(doneCount), 32'd1);
            if (checkLen)
                checkOutput("sweep_len", 32'(lastDoneCyc - startCyc),
                            32'(NUM_REGS * (SETTLE + 1) + 1 + bpCycles));
        end
        repeat (2) applyStimulus(0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        nChecks = 0; nPass = 0; cyc = 0;
        salt = '0; start = 0; abort = 0; outReady = 0;
        rstn = 1'b0;
        modelReset();
        clearCounters();
        repeat (2) @(negedge clk);
        checkReset("por");
        rstn = 1'b1;
        repeat (3) applyStimulus(0, 0, 1);

        $display("[TB] basic sweep, ready held high");
        runSweep(100, 0, 0, 0, 1);

        $display("[TB] backpressure on entry 1 plus random stalls");
        runSweep(100, 0, 0, 1, 1);
        runSweep(60, 0, 0, 1, 1);

        $display("[TB] abort with ready in the same cycle on entry 2");
        clearCounters();
        applyStimulus(1, 0, 1);
        guard = 0;
        while (!(mValid && mAddr == 2) && guard < 100) begin
            applyStimulus(0, 0, 1);
            guard++;
        end
        if (guard >= 100) checkOutput("abort_reach_timeout", 32'd0, 32'd1);
        applyStimulus(0, 1, 1);
        repeat (4) applyStimulus(0, 0, 1);
        checkOutput("abort_entries", 32'(hsCount), 32'd2);
        checkOutput("abort_done", 32'(doneCount), 32'd0);
        runSweep(100, 0, 0, 0, 1);

        $display("[TB] start pulses during sweep and DONE");
        runSweep(75, 15, 0, 0, 1);

        $display("[TB] random aborts");
        repeat (3) runSweep(70, 10, 1, 0, 0);

        $display("[TB] reset mid-settle on address 60");
        clearCounters();
        applyStimulus(1, 0, 1);
        guard = 0;
        while (!(mBusy && !mValid && !mDone && mAddr == 60) && guard < 1000) begin
            applyStimulus(0, 0, 1);
            guard++;
        end
        if (guard >= 1000) checkOutput("reset_reach_timeout", 32'd0, 32'd1);
        #2 rstn = 1'b0;
        #1 checkReset("midreset");
        modelReset();
        @(negedge clk);
        checkReset("midreset_hold");
        rstn = 1'b1;
        clearCounters();
        repeat (8) applyStimulus(0, 0, 1);
        checkOutput("post_reset_done", 32'(doneCount), 32'd0);
        runSweep(80, 5, 0, 0, 1);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
